shift_register_universal: RTL and testbench



---
 rtl/shift_pkg.sv | 20 ++
 rtl/shift_register_universal_if.sv | 28 ++
 rtl/shift_frame_counter.sv | 43 ++++
 rtl/shift_register_universal.sv | 50 +++++
 tb/tb_shift_register_universal.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - mode encodings and width helpers for the universal shift register
package shift_pkg;

   localparam logic [1:0] MODE_HOLD = 2'b00;
   localparam logic [1:0] MODE_SHL  = 2'b01;
   localparam logic [1:0] MODE_SHR  = 2'b10;
   localparam logic [1:0] MODE_LOAD = 2'b11;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 64;

   function automatic bit width_ok(input int w);
      return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
   endfunction

   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/shift_register_universal_if.sv
// rtl/shift_register_universal_if.sv - control/data bundle between the shifter and its user
interface shift_register_universal_if
   import shift_pkg::*;
#(
   parameter int WIDTH = 16
);
   localparam int CNT_W = cnt_width(WIDTH);

   logic             EN;
   logic [1:0]       MODE;
   logic             IN;
   logic [WIDTH-1:0] PAR_IN;
   logic [WIDTH-1:0] OUT;
   logic             SER_OUT;
   logic [CNT_W-1:0] COUNT;
   logic             FRAME_DONE;

   modport master (
      output EN, MODE, IN, PAR_IN,
      input  OUT, SER_OUT, COUNT, FRAME_DONE
   );

   modport slave (
      input  EN, MODE, IN, PAR_IN,
      output OUT, SER_OUT, COUNT, FRAME_DONE
   );

endinterface

// File: rtl/shift_frame_counter.sv
// rtl/shift_frame_counter.sv - counts shifts per WIDTH-bit frame and pulses on each wrap
module shift_frame_counter
   import shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                        CLK,
   input  logic                        RESETN,
   input  logic                        SHIFT,
   input  logic                        CLEAR,
   output logic [cnt_width(WIDTH)-1:0] COUNT,
   output logic                        FRAME_DONE
);
   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [CNT_W-1:0] r_count;
   logic             r_done;

   // CLEAR wins over a wrapping shift, so a load never raises the pulse
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_count <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (CLEAR) begin
            r_count <= '0;
         end else if (SHIFT) begin
            if (r_count == LAST) begin
               r_count <= '0;
               r_done  <= 1'b1;
            end else begin
               r_count <= r_count + CNT_W'(1);
            end
         end
      end
   end

   assign COUNT      = r_count;
   assign FRAME_DONE = r_done;

endmodule

// File: rtl/shift_register_universal.sv
// rtl/shift_register_universal.sv - universal shift register with load, hold, both shifts and frame tracking
module shift_register_universal
   import shift_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic CLK,
   input  logic RESETN,
   shift_register_universal_if.slave bus
);
   if (!width_ok(WIDTH)) begin : g_bad_width
      $error("shift_register_universal: WIDTH out of range 2..64");
   end

   logic [WIDTH-1:0] r_out;
   logic             w_shift;
   logic             w_clear;

   assign w_shift = bus.EN && ((bus.MODE == MODE_SHL) || (bus.MODE == MODE_SHR));
   assign w_clear = bus.EN && (bus.MODE == MODE_LOAD);

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_out <= '0;
      end else if (bus.EN) begin
         case (bus.MODE)
            MODE_SHL:  r_out <= {r_out[WIDTH-2:0], bus.IN};
            MODE_SHR:  r_out <= {bus.IN, r_out[WIDTH-1:1]};
            MODE_LOAD: r_out <= bus.PAR_IN;
            default:   r_out <= r_out;
         endcase
      end
   end

   // Serial output taps the end the data is leaving from
   assign bus.SER_OUT = (bus.MODE == MODE_SHR) ? r_out[0] : r_out[WIDTH-1];
   assign bus.OUT     = r_out;

   shift_frame_counter #(
      .WIDTH(WIDTH)
   ) u_frame_counter (
      .CLK       (CLK),
      .RESETN    (RESETN),
      .SHIFT     (w_shift),
      .CLEAR     (w_clear),
      .COUNT     (bus.COUNT),
      .FRAME_DONE(bus.FRAME_DONE)
   );

endmodule

// File: tb/tb_shift_register_universal.sv
// tb/tb_shift_register_universal.sv - directed self-checking bench for 16-bit and 5-bit shifters
module tb_shift_register_universal;
   import shift_pkg::*;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   pulses;

   shift_register_universal_if #(.WIDTH(16)) if16 ();
   shift_register_universal_if #(.WIDTH(5))  if5 ();

   shift_register_universal #(.WIDTH(16)) dut16 (
      .CLK   (clk),
      .RESETN(rst_n),
      .bus   (if16)
   );

   shift_register_universal #(.WIDTH(5)) dut5 (
      .CLK   (clk),
      .RESETN(rst_n),
      .bus   (if5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive16(input logic en, input logic [1:0] mode, input logic in_bit, input logic [15:0] par);
      if16.EN     = en;
      if16.MODE   = mode;
      if16.IN     = in_bit;
      if16.PAR_IN = par;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst_n   = 1'b0;
      drive16(1'b0, MODE_HOLD, 1'b0, 16'h0000);
      if5.EN = 1'b0; if5.MODE = MODE_HOLD; if5.IN = 1'b0; if5.PAR_IN = 5'b0;
      tick();
      tick();
      check("rst_out", if16.OUT, 16'h0000);
      check("rst_count", if16.COUNT, 0);
      check("rst_fd", if16.FRAME_DONE, 1'b0);
      check("rst5_out", if5.OUT, 5'b0);
      rst_n = 1'b1;

      // Full left-shift frame of ones
      drive16(1'b1, MODE_SHL, 1'b1, 16'h0000);
      for (int i = 1; i <= 16; i++) begin
         tick();
         check($sformatf("shl_out_%0d", i), if16.OUT, (64'd1 << i) - 64'd1);
         check($sformatf("shl_fd_%0d", i), if16.FRAME_DONE, (i == 16));
         check($sformatf("shl_cnt_%0d", i), if16.COUNT, i % 16);
      end
      drive16(1'b1, MODE_HOLD, 1'b0, 16'h0000);
      tick();
      check("shl_fd_clear", if16.FRAME_DONE, 1'b0);
      check("hold_out", if16.OUT, 16'hFFFF);

      // Load then shift right, watching SER_OUT
      drive16(1'b1, MODE_LOAD, 1'b0, 16'hA5C3);
      tick();
      check("load_out", if16.OUT, 16'hA5C3);
      check("load_cnt", if16.COUNT, 0);
      drive16(1'b1, MODE_HOLD, 1'b0, 16'h0000);
      #1;
      check("ser_msb_hold", if16.SER_OUT, 1'b1);
      drive16(1'b1, MODE_SHR, 1'b0, 16'h0000);
      #1;
      check("ser_0", if16.SER_OUT, 1'b1);
      tick(); check("ser_1", if16.SER_OUT, 1'b1);
      tick(); check("ser_2", if16.SER_OUT, 1'b0);
      tick(); check("ser_3", if16.SER_OUT, 1'b0);
      tick(); check("ser_4", if16.SER_OUT, 1'b0);
      check("shr_out", if16.OUT, 16'h0A5C);
      check("shr_cnt", if16.COUNT, 4);
      drive16(1'b1, MODE_HOLD, 1'b0, 16'h0000);
      #1;
      check("ser_msb_0a5c", if16.SER_OUT, 1'b0);

      // Mid-frame disable and hold
      drive16(1'b1, MODE_LOAD, 1'b0, 16'h0000);
      tick();
      drive16(1'b1, MODE_SHL, 1'b1, 16'h0000);
      repeat (5) tick();
      drive16(1'b0, MODE_SHL, 1'b1, 16'h0000);
      for (int i = 0; i < 3; i++) begin
         tick();
         check($sformatf("dis_out_%0d", i), if16.OUT, 16'h001F);
         check($sformatf("dis_cnt_%0d", i), if16.COUNT, 5);
      end
      drive16(1'b1, MODE_HOLD, 1'b1, 16'h0000);
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("hld_out_%0d", i), if16.OUT, 16'h001F);
         check($sformatf("hld_cnt_%0d", i), if16.COUNT, 5);
      end
      pulses = 0;
      drive16(1'b1, MODE_SHL, 1'b1, 16'h0000);
      for (int i = 1; i <= 11; i++) begin
         tick();
         if (if16.FRAME_DONE) pulses++;
         if (i == 11) check("resume_fd_11", if16.FRAME_DONE, 1'b1);
      end
      drive16(1'b1, MODE_HOLD, 1'b0, 16'h0000);
      tick();
      if (if16.FRAME_DONE) pulses++;
      check("resume_pulses", pulses, 1);
      check("resume_out", if16.OUT, 16'hFFFF);

      // Load on the wrap cycle
      drive16(1'b1, MODE_LOAD, 1'b0, 16'h0000);
      tick();
      drive16(1'b1, MODE_SHL, 1'b0, 16'h0000);
      repeat (15) tick();
      check("pre_wrap_cnt", if16.COUNT, 15);
      drive16(1'b1, MODE_LOAD, 1'b0, 16'h1234);
      tick();
      check("wrapload_out", if16.OUT, 16'h1234);
      check("wrapload_cnt", if16.COUNT, 0);
      check("wrapload_fd", if16.FRAME_DONE, 1'b0);
      drive16(1'b1, MODE_HOLD, 1'b0, 16'h0000);
      tick();
      check("wrapload_fd_next", if16.FRAME_DONE, 1'b0);

      // Asynchronous reset between edges, mid-frame
      drive16(1'b1, MODE_LOAD, 1'b0, 16'h0000);
      tick();
      drive16(1'b1, MODE_SHL, 1'b1, 16'h0000);
      repeat (9) tick();
      check("pre_rst_out", if16.OUT, 16'h01FF);
      check("pre_rst_cnt", if16.COUNT, 9);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_out", if16.OUT, 16'h0000);
      check("arst_cnt", if16.COUNT, 0);
      check("arst_fd", if16.FRAME_DONE, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("post_rst_cnt", if16.COUNT, 1);
      check("post_rst_out", if16.OUT, 16'h0001);

      // WIDTH=5 instance, two back-to-back frames
      drive16(1'b0, MODE_HOLD, 1'b0, 16'h0000);
      if5.EN = 1'b1; if5.MODE = MODE_SHL;
      for (int i = 0; i < 10; i++) begin
         logic [9:0] stream;
         stream = 10'b10110_11111;
         if5.IN = stream[9 - i];
         tick();
         check($sformatf("w5_fd_%0d", i), if5.FRAME_DONE, (i == 4) || (i == 9));
         if (i == 4) check("w5_out_a", if5.OUT, 5'b10110);
         if (i == 9) check("w5_out_b", if5.OUT, 5'b11111);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
